// File: rtl/rw_recovery_requester.sv
// Register-writeback stage recovery requester: holds the oldest misspeculating op and hands it to the recovery manager.
// Optional stall counter enabled by defining RSD_RW_RECOVERY_PERF_COUNTER_EN.
module rw_recovery_requester #(
   parameter int WB_WIDTH           = 4,
   parameter int AL_INDEX_WIDTH     = 6,
   parameter int ADDR_WIDTH         = 32,
   parameter int BR_HIST_WIDTH      = 10,
   parameter int REFETCH_TYPE_WIDTH = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wbValid       [WB_WIDTH],
   input  logic [AL_INDEX_WIDTH-1:0]     wbAlPtr       [WB_WIDTH],
   input  logic [REFETCH_TYPE_WIDTH-1:0] wbRefetchType [WB_WIDTH],
   input  logic [ADDR_WIDTH-1:0]         wbRecoveredPC [WB_WIDTH],
   input  logic [BR_HIST_WIDTH-1:0]      wbBrHistory   [WB_WIDTH],
   input  logic [AL_INDEX_WIDTH-1:0]     alHeadPtr,
   input  logic                          toRecoveryPhase,
   input  logic                          recoveryFromRwStage,
   input  logic                          toCommitPhase,
   input  logic                          unableToStartRecovery,
   output logic                          exceptionDetectedInRwStage,
   output logic [REFETCH_TYPE_WIDTH-1:0] refetchTypeFromRwStage,
   output logic [ADDR_WIDTH-1:0]         recoveredPC_FromRwStage,
   output logic [BR_HIST_WIDTH-1:0]      recoveredBrHistoryFromRwStage,
   output logic [AL_INDEX_WIDTH-1:0]     requestAlPtr,
   output logic                          busy,
   output logic [15:0]                   perfPendingCycles
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PENDING    = 2'd1,
      RECOVERING = 2'd2
   } StateT;

   StateT state;

   logic                          selValid;
   logic [AL_INDEX_WIDTH-1:0]     selAge;
   logic [AL_INDEX_WIDTH-1:0]     selPtr;
   logic [REFETCH_TYPE_WIDTH-1:0] selType;
   logic [ADDR_WIDTH-1:0]         selPC;
   logic [BR_HIST_WIDTH-1:0]      selHist;
   logic [AL_INDEX_WIDTH-1:0]     laneAge;
   logic [AL_INDEX_WIDTH-1:0]     heldAge;
   logic                          selOlder;

   // Age is distance from the ActiveList head; modular subtraction absorbs wrap-around.
   // Strict '<' keeps the lowest lane index on equal age.
   always_comb begin
      selValid = 1'b0;
      selAge   = '0;
      selPtr   = '0;
      selType  = '0;
      selPC    = '0;
      selHist  = '0;
      laneAge  = '0;
      for (int unsigned i = 0; i < WB_WIDTH; i++) begin
         laneAge = wbAlPtr[i] - alHeadPtr;
         if (wbValid[i] && (!selValid || (laneAge < selAge))) begin
            selValid = 1'b1;
            selAge   = laneAge;
            selPtr   = wbAlPtr[i];
            selType  = wbRefetchType[i];
            selPC    = wbRecoveredPC[i];
            selHist  = wbBrHistory[i];
         end
      end
   end

   assign heldAge  = requestAlPtr - alHeadPtr;
   assign selOlder = selValid && (selAge < heldAge);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                         <= IDLE;
         exceptionDetectedInRwStage    <= 1'b0;
         refetchTypeFromRwStage        <= '0;
         recoveredPC_FromRwStage       <= '0;
         recoveredBrHistoryFromRwStage <= '0;
         requestAlPtr                  <= '0;
         busy                          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (toRecoveryPhase) begin
                  state <= RECOVERING;
                  busy  <= 1'b1;
               end else if (selValid) begin
                  state                         <= PENDING;
                  busy                          <= 1'b1;
                  exceptionDetectedInRwStage    <= 1'b1;
                  refetchTypeFromRwStage        <= selType;
                  recoveredPC_FromRwStage       <= selPC;
                  recoveredBrHistoryFromRwStage <= selHist;
                  requestAlPtr                  <= selPtr;
               end
            end
            PENDING: begin
               // A started recovery always wins over a same-cycle lane event; a commit-stage
               // recovery makes the held request moot, so its fields are cleared.
               if (toRecoveryPhase) begin
                  state                      <= RECOVERING;
                  exceptionDetectedInRwStage <= 1'b0;
                  if (!recoveryFromRwStage) begin
                     refetchTypeFromRwStage        <= '0;
                     recoveredPC_FromRwStage       <= '0;
                     recoveredBrHistoryFromRwStage <= '0;
                     requestAlPtr                  <= '0;
                  end
               end else if (selOlder) begin
                  refetchTypeFromRwStage        <= selType;
                  recoveredPC_FromRwStage       <= selPC;
                  recoveredBrHistoryFromRwStage <= selHist;
                  requestAlPtr                  <= selPtr;
               end
            end
            RECOVERING: begin
               if (toCommitPhase) begin
                  state                         <= IDLE;
                  busy                          <= 1'b0;
                  refetchTypeFromRwStage        <= '0;
                  recoveredPC_FromRwStage       <= '0;
                  recoveredBrHistoryFromRwStage <= '0;
                  requestAlPtr                  <= '0;
               end
            end
            default: begin
               state                      <= IDLE;
               busy                       <= 1'b0;
               exceptionDetectedInRwStage <= 1'b0;
            end
         endcase
      end
   end

`ifdef RSD_RW_RECOVERY_PERF_COUNTER_EN
   logic [15:0] perfCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perfCnt <= '0;
      end else if ((state == PENDING) && unableToStartRecovery && (perfCnt != '1)) begin
         perfCnt <= perfCnt + 16'd1;
      end
   end

   assign perfPendingCycles = perfCnt;
`else
   logic unusedUnableToStart;

   assign unusedUnableToStart = unableToStartRecovery;
   assign perfPendingCycles   = '0;
`endif

endmodule

// File: tb/tb_rw_recovery_requester.sv
// Directed bench for rw_recovery_requester: capture, age arbitration, replacement, handshake and reset.
module tb_rw_recovery_requester;

   logic        clk;
   logic        rst;
   logic        wbValid       [4];
   logic [5:0]  wbAlPtr       [4];
   logic [2:0]  wbRefetchType [4];
   logic [31:0] wbRecoveredPC [4];
   logic [9:0]  wbBrHistory   [4];
   logic [5:0]  alHeadPtr;
   logic        toRecoveryPhase;
   logic        recoveryFromRwStage;
   logic        toCommitPhase;
   logic        unableToStartRecovery;
   logic        exceptionDetectedInRwStage;
   logic [2:0]  refetchTypeFromRwStage;
   logic [31:0] recoveredPC_FromRwStage;
   logic [9:0]  recoveredBrHistoryFromRwStage;
   logic [5:0]  requestAlPtr;
   logic        busy;
   logic [15:0] perfPendingCycles;

   int vectors;
   int miscompares;
   logic [15:0] expPerf;

   rw_recovery_requester #(
      .WB_WIDTH(4),
      .AL_INDEX_WIDTH(6),
      .ADDR_WIDTH(32),
      .BR_HIST_WIDTH(10),
      .REFETCH_TYPE_WIDTH(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wbValid(wbValid),
      .wbAlPtr(wbAlPtr),
      .wbRefetchType(wbRefetchType),
      .wbRecoveredPC(wbRecoveredPC),
      .wbBrHistory(wbBrHistory),
      .alHeadPtr(alHeadPtr),
      .toRecoveryPhase(toRecoveryPhase),
      .recoveryFromRwStage(recoveryFromRwStage),
      .toCommitPhase(toCommitPhase),
      .unableToStartRecovery(unableToStartRecovery),
      .exceptionDetectedInRwStage(exceptionDetectedInRwStage),
      .refetchTypeFromRwStage(refetchTypeFromRwStage),
      .recoveredPC_FromRwStage(recoveredPC_FromRwStage),
      .recoveredBrHistoryFromRwStage(recoveredBrHistoryFromRwStage),
      .requestAlPtr(requestAlPtr),
      .busy(busy),
      .perfPendingCycles(perfPendingCycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clrLanes();
      for (int i = 0; i < 4; i++) begin
         wbValid[i]       = 1'b0;
         wbAlPtr[i]       = '0;
         wbRefetchType[i] = '0;
         wbRecoveredPC[i] = '0;
         wbBrHistory[i]   = '0;
      end
   endtask

   task automatic setLane(input int i, input logic [5:0] ptr, input logic [2:0] typ,
                          input logic [31:0] pc, input logic [9:0] hist);
      wbValid[i]       = 1'b1;
      wbAlPtr[i]       = ptr;
      wbRefetchType[i] = typ;
      wbRecoveredPC[i] = pc;
      wbBrHistory[i]   = hist;
   endtask

   task automatic commitBack();
      toCommitPhase = 1'b1;
      tick();
      toCommitPhase = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
`ifdef RSD_RW_RECOVERY_PERF_COUNTER_EN
      expPerf = 16'd5;
`else
      expPerf = 16'd0;
`endif
      rst                   = 1'b1;
      alHeadPtr             = '0;
      toRecoveryPhase       = 1'b0;
      recoveryFromRwStage   = 1'b0;
      toCommitPhase         = 1'b0;
      unableToStartRecovery = 1'b0;
      clrLanes();
      #1;
      chk("reset_exc", 32'(exceptionDetectedInRwStage), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ptr", 32'(requestAlPtr), 32'd0);
      chk("reset_pc", 32'(recoveredPC_FromRwStage), 32'd0);
      chk("reset_perf", 32'(perfPendingCycles), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Scenario 1: single lane capture with one-cycle latency
      alHeadPtr = 6'd10;
      setLane(2, 6'd12, 3'd3, 32'h1000, 10'h155);
      chk("s1_exc_before_edge", 32'(exceptionDetectedInRwStage), 32'd0);
      tick();
      clrLanes();
      chk("s1_exc", 32'(exceptionDetectedInRwStage), 32'd1);
      chk("s1_pc", 32'(recoveredPC_FromRwStage), 32'h1000);
      chk("s1_ptr", 32'(requestAlPtr), 32'd12);
      chk("s1_type", 32'(refetchTypeFromRwStage), 32'd3);
      chk("s1_hist", 32'(recoveredBrHistoryFromRwStage), 32'h155);
      chk("s1_busy", 32'(busy), 32'd1);
      tick();
      chk("s1_ptr_hold", 32'(requestAlPtr), 32'd12);
      toRecoveryPhase     = 1'b1;
      recoveryFromRwStage = 1'b1;
      tick();
      toRecoveryPhase     = 1'b0;
      recoveryFromRwStage = 1'b0;
      chk("s1_rec_exc", 32'(exceptionDetectedInRwStage), 32'd0);
      chk("s1_rec_busy", 32'(busy), 32'd1);
      commitBack();
      chk("s1_idle_busy", 32'(busy), 32'd0);

      // Scenario 2: wrap-around age arbitration and equal-age tie to lowest lane
      alHeadPtr = 6'd60;
      setLane(0, 6'd2,  3'd1, 32'h2000, 10'h001);
      setLane(1, 6'd62, 3'd2, 32'h2100, 10'h002);
      setLane(3, 6'd62, 3'd4, 32'h2300, 10'h003);
      tick();
      clrLanes();
      chk("s2_ptr", 32'(requestAlPtr), 32'd62);
      chk("s2_pc", 32'(recoveredPC_FromRwStage), 32'h2100);
      chk("s2_type", 32'(refetchTypeFromRwStage), 32'd2);
      toRecoveryPhase = 1'b1;
      tick();
      toRecoveryPhase = 1'b0;
      commitBack();

      // Scenario 3: older event replaces, younger and equal-age events are dropped
      alHeadPtr = 6'd10;
      setLane(0, 6'd20, 3'd1, 32'h3000, 10'h010);
      tick();
      clrLanes();
      chk("s3_ptr20", 32'(requestAlPtr), 32'd20);
      setLane(3, 6'd15, 3'd5, 32'h3500, 10'h050);
      tick();
      clrLanes();
      chk("s3_ptr15", 32'(requestAlPtr), 32'd15);
      chk("s3_pc15", 32'(recoveredPC_FromRwStage), 32'h3500);
      setLane(1, 6'd25, 3'd6, 32'h3600, 10'h060);
      tick();
      clrLanes();
      chk("s3_younger_ptr", 32'(requestAlPtr), 32'd15);
      chk("s3_younger_pc", 32'(recoveredPC_FromRwStage), 32'h3500);
      setLane(2, 6'd15, 3'd7, 32'h3700, 10'h070);
      tick();
      clrLanes();
      chk("s3_equal_pc", 32'(recoveredPC_FromRwStage), 32'h3500);
      // head moves past the held op: held age 63, new event age 4
      alHeadPtr = 6'd16;
      setLane(0, 6'd20, 3'd2, 32'h3800, 10'h080);
      tick();
      clrLanes();
      chk("s3_wrap_ptr", 32'(requestAlPtr), 32'd20);
      chk("s3_wrap_pc", 32'(recoveredPC_FromRwStage), 32'h3800);

      // Scenario 4: handshake stall then RW-stage recovery
      unableToStartRecovery = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("s4_stall_ptr", 32'(requestAlPtr), 32'd20);
         chk("s4_stall_exc", 32'(exceptionDetectedInRwStage), 32'd1);
      end
      unableToStartRecovery = 1'b0;
      toRecoveryPhase       = 1'b1;
      recoveryFromRwStage   = 1'b1;
      tick();
      toRecoveryPhase     = 1'b0;
      recoveryFromRwStage = 1'b0;
      chk("s4_rec_exc", 32'(exceptionDetectedInRwStage), 32'd0);
      chk("s4_rec_busy", 32'(busy), 32'd1);
      chk("s4_perf", 32'(perfPendingCycles), 32'(expPerf));
      setLane(0, 6'd17, 3'd1, 32'h4000, 10'h011);
      tick();
      chk("s4_rec_ignore_exc", 32'(exceptionDetectedInRwStage), 32'd0);
      chk("s4_rec_ignore_ptr", 32'(requestAlPtr), 32'd20);
      commitBack();
      clrLanes();
      chk("s4_idle_busy", 32'(busy), 32'd0);
      chk("s4_idle_exc", 32'(exceptionDetectedInRwStage), 32'd0);
      chk("s4_idle_ptr", 32'(requestAlPtr), 32'd0);

      // IDLE: commit-stage recovery beats same-cycle lane event
      setLane(1, 6'd18, 3'd1, 32'h4100, 10'h012);
      toRecoveryPhase = 1'b1;
      tick();
      clrLanes();
      toRecoveryPhase = 1'b0;
      chk("idle_rec_busy", 32'(busy), 32'd1);
      chk("idle_rec_exc", 32'(exceptionDetectedInRwStage), 32'd0);
      tick();
      chk("idle_rec_exc2", 32'(exceptionDetectedInRwStage), 32'd0);
      commitBack();

      // Scenario 5: commit-stage recovery in PENDING discards request and lane data
      alHeadPtr = 6'd10;
      setLane(0, 6'd30, 3'd1, 32'h5000, 10'h020);
      tick();
      clrLanes();
      chk("s5_exc", 32'(exceptionDetectedInRwStage), 32'd1);
      setLane(2, 6'd11, 3'd3, 32'h5100, 10'h021);
      toRecoveryPhase = 1'b1;
      tick();
      clrLanes();
      toRecoveryPhase = 1'b0;
      chk("s5_exc_drop", 32'(exceptionDetectedInRwStage), 32'd0);
      chk("s5_ptr_drop", 32'(requestAlPtr), 32'd0);
      chk("s5_pc_drop", 32'(recoveredPC_FromRwStage), 32'd0);
      chk("s5_busy", 32'(busy), 32'd1);
      tick();
      chk("s5_no_capture", 32'(exceptionDetectedInRwStage), 32'd0);
      commitBack();

      // Scenario 6: asynchronous reset mid-PENDING
      setLane(0, 6'd40, 3'd2, 32'h6000, 10'h030);
      tick();
      clrLanes();
      chk("s6_exc", 32'(exceptionDetectedInRwStage), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("s6_rst_exc", 32'(exceptionDetectedInRwStage), 32'd0);
      chk("s6_rst_busy", 32'(busy), 32'd0);
      chk("s6_rst_ptr", 32'(requestAlPtr), 32'd0);
      chk("s6_rst_pc", 32'(recoveredPC_FromRwStage), 32'd0);
      chk("s6_rst_perf", 32'(perfPendingCycles), 32'd0);
      #3;
      rst = 1'b0;
      tick();
      chk("s6_post_busy", 32'(busy), 32'd0);
      chk("s6_post_exc", 32'(exceptionDetectedInRwStage), 32'd0);
      setLane(0, 6'd41, 3'd1, 32'h6100, 10'h031);
      tick();
      clrLanes();
      chk("s6_recapture_exc", 32'(exceptionDetectedInRwStage), 32'd1);
      chk("s6_recapture_ptr", 32'(requestAlPtr), 32'd41);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rw_recovery_requester.md
RW_RECOVERY_REQUESTER -- requirements
Module: rw_recovery_requester

Interface
REQ-001 Parameters SHALL be: WB_WIDTH, default 4, number of writeback lanes reporting misspeculation; AL_INDEX_WIDTH, default 6, ActiveList pointer width (64 entries); ADDR_WIDTH, default 32, PC width; BR_HIST_WIDTH, default 10, global branch history width; REFETCH_TYPE_WIDTH, default 3, refetch-type encoding width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock;
- rst  in  1  asynchronous, active-high reset;
- wbValid[WB_WIDTH]  in  1 each  lane reports a refetch-requiring event this cycle;
- wbAlPtr[WB_WIDTH]  in  AL_INDEX_WIDTH  ActiveList index of the reporting op;
- wbRefetchType[WB_WIDTH]  in  REFETCH_TYPE_WIDTH  refetch type;
- wbRecoveredPC[WB_WIDTH]  in  ADDR_WIDTH  restart PC;
- wbBrHistory[WB_WIDTH]  in  BR_HIST_WIDTH  history checkpoint;
- alHeadPtr  in  AL_INDEX_WIDTH  ActiveList head, the oldest in-flight op;
- toRecoveryPhase  in  1  recovery-manager start pulse;
- recoveryFromRwStage  in  1  with toRecoveryPhase, the started recovery is this block's request;
- toCommitPhase  in  1  recovery-complete pulse;
- unableToStartRecovery  in  1  recovery manager cannot accept now;
- exceptionDetectedInRwStage  out  1  request valid;
- refetchTypeFromRwStage  out  REFETCH_TYPE_WIDTH;
- recoveredPC_FromRwStage  out  ADDR_WIDTH;
- recoveredBrHistoryFromRwStage  out  BR_HIST_WIDTH;
- requestAlPtr  out  AL_INDEX_WIDTH  ActiveList index of the held request;
- busy  out  1  state is not IDLE;
- perfPendingCycles  out  16  stall counter (see Configuration).

Function
REQ-003 Age of a pointer SHALL be (ptr - alHeadPtr) modulo 2^AL_INDEX_WIDTH; a smaller age is older, and wrap-around SHALL be handled by this subtraction alone.
REQ-004 Among valid lanes in one cycle, the lane with the smallest age SHALL be selected; on equal age, the lowest lane index SHALL win.
REQ-005 The FSM SHALL have states IDLE, PENDING and RECOVERING.
REQ-006 IDLE: when any wbValid is set, the selected lane's fields SHALL be registered and the state SHALL move to PENDING on the next edge (1-cycle latency to exceptionDetectedInRwStage).
REQ-007 PENDING: exceptionDetectedInRwStage SHALL be 1, and the outputs SHALL present the held fields unchanged except as REQ-008 allows.
REQ-008 PENDING: if the selected lane's age is strictly smaller than the held request's age (both computed against the current alHeadPtr), the held fields SHALL be replaced next cycle; equal or younger events SHALL be dropped.
REQ-009 PENDING: toRecoveryPhase=1 with recoveryFromRwStage=1 SHALL move to RECOVERING; toRecoveryPhase=1 with recoveryFromRwStage=0 (commit-stage recovery) SHALL discard the request and move to RECOVERING.
REQ-010 The handshake rule applies in PENDING: while unableToStartRecovery=1 the request SHALL be held, and exceptionDetectedInRwStage SHALL stay asserted.
REQ-011 RECOVERING: exceptionDetectedInRwStage SHALL be 0, all wbValid SHALL be ignored, and toCommitPhase=1 SHALL return to IDLE.
REQ-012 IDLE: toRecoveryPhase=1 (commit-stage recovery) SHALL move to RECOVERING, ignoring same-cycle wbValid.
REQ-013 Recovery start takes priority over capture: when toRecoveryPhase=1 and wbValid are set in the same cycle, the lane data SHALL be discarded.
REQ-014 busy SHALL be 1 in PENDING and RECOVERING.

Reset
REQ-015 rst=1 SHALL asynchronously force IDLE, and all registered outputs SHALL be 0, including perfPendingCycles.
REQ-016 Reset during PENDING or RECOVERING SHALL drop the request with no residual assertion.

Configuration
REQ-017 With RSD_RW_RECOVERY_PERF_COUNTER_EN defined, perfPendingCycles SHALL increment, saturating at 16'hFFFF, each cycle that the state is PENDING and unableToStartRecovery=1; it SHALL never clear except on reset. Without the macro, perfPendingCycles SHALL be constant 0 and no counter SHALL be built.

Verification
REQ-018 Scenario 1: alHeadPtr=10, lane2 valid ptr=12, PC=0x1000 -> next cycle exceptionDetectedInRwStage=1, recoveredPC_FromRwStage=0x1000, requestAlPtr=12.
REQ-019 Scenario 2: head=60, lane0 ptr=2 and lane1 ptr=62 together -> lane1 is selected (age 2 vs 6), requestAlPtr=62.
REQ-020 Scenario 3: held ptr=20 with head=10; new lane event ptr=15 -> request replaced by ptr 15; a later event ptr=25 -> held ptr stays 15.
REQ-021 Scenario 4: PENDING with unableToStartRecovery=1 for 5 cycles, then toRecoveryPhase=1 and recoveryFromRwStage=1 -> request stable for 5 cycles, RECOVERING, output 0, perfPendingCycles=5 (macro on) or 0 (macro off); toCommitPhase -> busy=0.
REQ-022 Scenario 5: PENDING, then toRecoveryPhase=1 and recoveryFromRwStage=0 with lane valid in the same cycle -> request dropped, no new capture, RECOVERING.
REQ-023 Scenario 6: rst asserted mid-PENDING, asynchronous to clk -> outputs 0 immediately; after release, IDLE with busy=0.
